// File: rtl/spmm_pkg.sv
// Shared widths, BRAM word layouts and feeder state encoding for the SpMM row path.
package spmm_pkg;
    localparam int DATA_WIDTH        = 8;
    localparam int NUM_FEATURE_IN    = 1433;
    localparam int MAX_NODES         = 168;
    localparam int TOTAL_NODES       = 13264;
    localparam int H_NUM_SPARSE_DATA = 242101;

    localparam int COL_IDX_W  = $clog2(NUM_FEATURE_IN);
    localparam int ROW_LEN_W  = $clog2(NUM_FEATURE_IN);
    localparam int NUM_NODE_W = $clog2(MAX_NODES);
    localparam int NI_ADDR_W  = $clog2(TOTAL_NODES);
    localparam int H_ADDR_W   = $clog2(H_NUM_SPARSE_DATA);

    typedef struct packed {
        logic [ROW_LEN_W-1:0]  row_len;
        logic [NUM_NODE_W-1:0] num_node;
        logic                  src_flag;
    } node_info_t;

    typedef struct packed {
        logic [COL_IDX_W-1:0]  col_idx;
        logic [DATA_WIDTH-1:0] val;
    } h_elem_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LATCH,
        S_CREDIT,
        S_STREAM
    } feeder_state_e;
endpackage

// File: rtl/spmm_row_feeder.sv
// Streams CSR rows of H from BRAM to one SpMM PE: row header with first element, then gapless elements.
// Latency: start_i to first pe_vld_o is 5 cycles; 4 cycles from a row's last element to the next pe_vld_o.
// Backpressure: every row but the first of a run waits in CREDIT for pe_rdy_i; no BRAM reads while stalled.
module spmm_row_feeder
    import spmm_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic [NI_ADDR_W-1:0]              row_base_i,
    input  logic [NI_ADDR_W:0]                num_rows_i,
    input  logic [H_ADDR_W-1:0]               h_base_i,
    output logic [NI_ADDR_W-1:0]              ni_addrb,
    input  logic [ROW_LEN_W+NUM_NODE_W:0]     ni_dout,
    output logic [H_ADDR_W-1:0]               h_addrb,
    input  logic [COL_IDX_W+DATA_WIDTH-1:0]   h_dout,
    output logic                              spmm_vld_o,
    output logic                              pe_vld_o,
    input  logic                              pe_rdy_i,
    output logic [COL_IDX_W-1:0]              col_idx_o,
    output logic [DATA_WIDTH-1:0]             val_o,
    output logic [ROW_LEN_W-1:0]              row_len_o,
    output logic [NUM_NODE_W-1:0]             num_node_o,
    output logic                              src_flag_o,
    output logic                              done_o
);
    feeder_state_e         state_q, state_d;
    logic [NI_ADDR_W-1:0]  row_ptr_q, row_ptr_d;
    logic [H_ADDR_W-1:0]   h_ptr_q, h_ptr_d;
    logic [NI_ADDR_W:0]    rows_left_q, rows_left_d;
    logic                  first_row_q, first_row_d;
    node_info_t            ni_lat_q, ni_lat_d;
    logic [ROW_LEN_W-1:0]  cnt_q, cnt_d;
    logic [NI_ADDR_W-1:0]  ni_addr_q, ni_addr_d;
    logic [H_ADDR_W-1:0]   h_addr_q, h_addr_d;
    logic [COL_IDX_W-1:0]  col_q, col_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic                  pe_vld_q, pe_vld_d;
    logic                  spmm_vld_q, spmm_vld_d;
    logic [ROW_LEN_W-1:0]  row_len_q, row_len_d;
    logic [NUM_NODE_W-1:0] num_node_q, num_node_d;
    logic                  src_flag_q, src_flag_d;
    logic                  fin_q, fin_d;
    logic                  done_q, done_d;

    node_info_t            ni_in;
    h_elem_t               h_in;
    logic                  zero_row;
    logic [ROW_LEN_W-1:0]  eff_len;
    logic                  more;

    assign ni_in    = node_info_t'(ni_dout);
    assign h_in     = h_elem_t'(h_dout);
    // An empty row still emits one zero element so the PE sees every row.
    assign zero_row = (ni_lat_q.row_len == '0);
    assign eff_len  = zero_row ? ROW_LEN_W'(1) : ni_lat_q.row_len;
    assign more     = ({1'b0, cnt_q} + (ROW_LEN_W+1)'(1)) < {1'b0, eff_len};

    always_comb begin
        state_d     = state_q;
        row_ptr_d   = row_ptr_q;
        h_ptr_d     = h_ptr_q;
        rows_left_d = rows_left_q;
        first_row_d = first_row_q;
        ni_lat_d    = ni_lat_q;
        cnt_d       = cnt_q;
        ni_addr_d   = ni_addr_q;
        h_addr_d    = h_addr_q;
        col_d       = col_q;
        val_d       = val_q;
        pe_vld_d    = 1'b0;
        spmm_vld_d  = spmm_vld_q & ~fin_q;
        row_len_d   = row_len_q;
        num_node_d  = num_node_q;
        src_flag_d  = src_flag_q;
        fin_d       = 1'b0;
        done_d      = fin_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    row_ptr_d   = row_base_i;
                    h_ptr_d     = h_base_i;
                    rows_left_d = num_rows_i;
                    first_row_d = 1'b1;
                    if (num_rows_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                ni_addr_d = row_ptr_q;
                state_d   = S_LATCH;
            end
            S_LATCH: begin
                ni_lat_d = ni_in;
                state_d  = S_CREDIT;
            end
            S_CREDIT: begin
                if (first_row_q || pe_rdy_i) begin
                    h_addr_d    = h_ptr_q;
                    cnt_d       = '0;
                    first_row_d = 1'b0;
                    row_len_d   = eff_len;
                    num_node_d  = ni_lat_q.num_node;
                    src_flag_d  = ni_lat_q.src_flag;
                    state_d     = S_STREAM;
                end
            end
            S_STREAM: begin
                col_d    = zero_row ? '0 : h_in.col_idx;
                val_d    = zero_row ? '0 : h_in.val;
                pe_vld_d = (cnt_q == '0);
                if (cnt_q == '0) begin
                    spmm_vld_d = 1'b1;
                end
                if (more) begin
                    h_addr_d = h_ptr_q + H_ADDR_W'(cnt_q) + H_ADDR_W'(1);
                    cnt_d    = cnt_q + ROW_LEN_W'(1);
                end else begin
                    h_ptr_d     = h_ptr_q + H_ADDR_W'(ni_lat_q.row_len);
                    row_ptr_d   = row_ptr_q + NI_ADDR_W'(1);
                    rows_left_d = rows_left_q - (NI_ADDR_W+1)'(1);
                    if (rows_left_q == (NI_ADDR_W+1)'(1)) begin
                        fin_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HDR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_ptr_q   <= '0;
            h_ptr_q     <= '0;
            rows_left_q <= '0;
            first_row_q <= 1'b0;
            ni_lat_q    <= '0;
            cnt_q       <= '0;
            ni_addr_q   <= '0;
            h_addr_q    <= '0;
            col_q       <= '0;
            val_q       <= '0;
            pe_vld_q    <= 1'b0;
            spmm_vld_q  <= 1'b0;
            row_len_q   <= '0;
            num_node_q  <= '0;
            src_flag_q  <= 1'b0;
            fin_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_ptr_q   <= row_ptr_d;
            h_ptr_q     <= h_ptr_d;
            rows_left_q <= rows_left_d;
            first_row_q <= first_row_d;
            ni_lat_q    <= ni_lat_d;
            cnt_q       <= cnt_d;
            ni_addr_q   <= ni_addr_d;
            h_addr_q    <= h_addr_d;
            col_q       <= col_d;
            val_q       <= val_d;
            pe_vld_q    <= pe_vld_d;
            spmm_vld_q  <= spmm_vld_d;
            row_len_q   <= row_len_d;
            num_node_q  <= num_node_d;
            src_flag_q  <= src_flag_d;
            fin_q       <= fin_d;
            done_q      <= done_d;
        end
    end

    // BRAM addresses are driven from next-state so the read is issued in the deciding cycle.
    assign ni_addrb   = ni_addr_d;
    assign h_addrb    = h_addr_d;
    assign spmm_vld_o = spmm_vld_q;
    assign pe_vld_o   = pe_vld_q;
    assign col_idx_o  = col_q;
    assign val_o      = val_q;
    assign row_len_o  = row_len_q;
    assign num_node_o = num_node_q;
    assign src_flag_o = src_flag_q;
    assign done_o     = done_q;
endmodule

// File: tb/tb_spmm_row_feeder.sv
// Directed and randomized runs of spmm_row_feeder against BRAM models and a row-list reference model.
module tb_spmm_row_feeder;
    import spmm_pkg::*;

    localparam int LOGN = 16384;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic                            start_i = 1'b0;
    logic [NI_ADDR_W-1:0]            row_base_i = '0;
    logic [NI_ADDR_W:0]              num_rows_i = '0;
    logic [H_ADDR_W-1:0]             h_base_i = '0;
    logic [NI_ADDR_W-1:0]            ni_addrb;
    logic [ROW_LEN_W+NUM_NODE_W:0]   ni_dout = '0;
    logic [H_ADDR_W-1:0]             h_addrb;
    logic [COL_IDX_W+DATA_WIDTH-1:0] h_dout = '0;
    logic                            spmm_vld_o, pe_vld_o, pe_rdy_i;
    logic [COL_IDX_W-1:0]            col_idx_o;
    logic [DATA_WIDTH-1:0]           val_o;
    logic [ROW_LEN_W-1:0]            row_len_o;
    logic [NUM_NODE_W-1:0]           num_node_o;
    logic                            src_flag_o, done_o;

    logic rdy_force = 1'b0, rdy_rand_en = 1'b0, rdy_rand_bit = 1'b0;
    assign pe_rdy_i = rdy_force | (rdy_rand_en & rdy_rand_bit);

    logic [ROW_LEN_W+NUM_NODE_W:0]   ni_mem [0:(1<<NI_ADDR_W)-1];
    logic [COL_IDX_W+DATA_WIDTH-1:0] h_mem  [0:(1<<H_ADDR_W)-1];

    typedef struct {
        int                    cyc;
        logic [COL_IDX_W-1:0]  col;
        logic [DATA_WIDTH-1:0] val;
        logic                  first;
        logic [ROW_LEN_W-1:0]  rlen;
        logic [NUM_NODE_W-1:0] nn;
        logic                  src;
    } el_t;

    el_t  elem_q[$];
    el_t  exp_q[$];
    int   done_q[$];
    logic spmm_log [0:LOGN-1];
    int   cyc = 0, checks = 0, errors = 0, rem = 0;

    spmm_row_feeder dut (
        .clk(clk), .rst(rst), .start_i(start_i), .row_base_i(row_base_i),
        .num_rows_i(num_rows_i), .h_base_i(h_base_i), .ni_addrb(ni_addrb),
        .ni_dout(ni_dout), .h_addrb(h_addrb), .h_dout(h_dout),
        .spmm_vld_o(spmm_vld_o), .pe_vld_o(pe_vld_o), .pe_rdy_i(pe_rdy_i),
        .col_idx_o(col_idx_o), .val_o(val_o), .row_len_o(row_len_o),
        .num_node_o(num_node_o), .src_flag_o(src_flag_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        ni_dout <= ni_mem[ni_addrb];
        h_dout  <= h_mem[h_addrb];
    end
    always @(negedge clk) rdy_rand_bit <= ($urandom_range(0, 2) != 0);

    // Frames each row by the row_len_o shown alongside its pe_vld_o.
    always @(negedge clk) begin
        if (cyc < LOGN) spmm_log[cyc] = spmm_vld_o;
        if (done_o) done_q.push_back(cyc);
        if (rst) begin
            rem = 0;
        end else if (pe_vld_o) begin
            elem_q.push_back('{cyc, col_idx_o, val_o, pe_vld_o, row_len_o, num_node_o, src_flag_o});
            rem = int'(row_len_o) - 1;
        end else if (rem > 0) begin
            elem_q.push_back('{cyc, col_idx_o, val_o, pe_vld_o, row_len_o, num_node_o, src_flag_o});
            rem = rem - 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_row(input logic [NI_ADDR_W-1:0] a, input int len, input int nn, input bit src);
        node_info_t ni;
        ni.row_len  = ROW_LEN_W'(len);
        ni.num_node = NUM_NODE_W'(nn);
        ni.src_flag = src;
        ni_mem[a] = ni;
    endtask

    task automatic set_h(input logic [H_ADDR_W-1:0] a, input int col, input int val);
        h_elem_t e;
        e.col_idx = COL_IDX_W'(col);
        e.val     = DATA_WIDTH'(val);
        h_mem[a] = e;
    endtask

    // Reference: rows are consecutive node_info entries; each row consumes row_len h_data words.
    task automatic build_exp(input logic [NI_ADDR_W-1:0] rb, input int n, input logic [H_ADDR_W-1:0] hb);
        logic [NI_ADDR_W-1:0] r;
        logic [H_ADDR_W-1:0]  h;
        node_info_t ni;
        h_elem_t    e;
        exp_q.delete();
        r = rb;
        h = hb;
        for (int k = 0; k < n; k++) begin
            ni = node_info_t'(ni_mem[r]);
            if (ni.row_len == '0) begin
                exp_q.push_back('{0, '0, '0, 1'b1, ROW_LEN_W'(1), ni.num_node, ni.src_flag});
            end else begin
                for (int j = 0; j < int'(ni.row_len); j++) begin
                    e = h_elem_t'(h_mem[h + H_ADDR_W'(j)]);
                    exp_q.push_back('{0, e.col_idx, e.val, (j == 0), ni.row_len, ni.num_node, ni.src_flag});
                end
            end
            h = h + H_ADDR_W'(ni.row_len);
            r = r + NI_ADDR_W'(1);
        end
    endtask

    task automatic do_start(input logic [NI_ADDR_W-1:0] rb, input int n, input logic [H_ADDR_W-1:0] hb, output int t);
        row_base_i = rb;
        num_rows_i = (NI_ADDR_W+1)'(n);
        h_base_i   = hb;
        start_i    = 1'b1;
        t          = cyc;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n = 0;
        while (done_q.size() == d0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " done_seen"}, (done_q.size() > d0), 1);
    endtask

    task automatic check_result(input string tag, input int t, input int e0, input int d0, input bit exact_gap);
        int last, first_c, bad;
        chk({tag, " n_elems"}, elem_q.size() - e0, exp_q.size());
        if (elem_q.size() - e0 == exp_q.size() && exp_q.size() > 0) begin
            first_c = elem_q[e0].cyc;
            chk({tag, " first_cyc"}, first_c, t + 5);
            for (int i = 0; i < exp_q.size(); i++) begin
                chk($sformatf("%s col[%0d]", tag, i), elem_q[e0+i].col, exp_q[i].col);
                chk($sformatf("%s val[%0d]", tag, i), elem_q[e0+i].val, exp_q[i].val);
                chk($sformatf("%s first[%0d]", tag, i), elem_q[e0+i].first, exp_q[i].first);
                chk($sformatf("%s row_len[%0d]", tag, i), elem_q[e0+i].rlen, exp_q[i].rlen);
                chk($sformatf("%s num_node[%0d]", tag, i), elem_q[e0+i].nn, exp_q[i].nn);
                chk($sformatf("%s src[%0d]", tag, i), elem_q[e0+i].src, exp_q[i].src);
                if (i > 0) begin
                    if (!exp_q[i].first)
                        chk($sformatf("%s consec[%0d]", tag, i), elem_q[e0+i].cyc, elem_q[e0+i-1].cyc + 1);
                    else if (exact_gap)
                        chk($sformatf("%s gap[%0d]", tag, i), elem_q[e0+i].cyc, elem_q[e0+i-1].cyc + 4);
                    else
                        chk($sformatf("%s gap_min[%0d]", tag, i), (elem_q[e0+i].cyc >= elem_q[e0+i-1].cyc + 4), 1);
                end
            end
            last = elem_q[elem_q.size()-1].cyc;
            chk({tag, " done_count"}, done_q.size() - d0, 1);
            if (done_q.size() > d0) chk({tag, " done_cyc"}, done_q[d0], last + 1);
            chk({tag, " spmm_before"}, spmm_log[first_c-1], 0);
            bad = 0;
            for (int c = first_c; c <= last; c++) if (spmm_log[c] !== 1'b1) bad++;
            chk({tag, " spmm_hold"}, bad, 0);
            chk({tag, " spmm_after"}, spmm_log[last+1], 0);
        end
    endtask

    task automatic run(input string tag, input logic [NI_ADDR_W-1:0] rb, input int n,
                       input logic [H_ADDR_W-1:0] hb, input bit exact_gap);
        int t, e0, d0;
        e0 = elem_q.size();
        d0 = done_q.size();
        build_exp(rb, n, hb);
        do_start(rb, n, hb, t);
        wait_done(tag, d0, 600);
        tick();
        check_result(tag, t, e0, d0, exact_gap);
    endtask

    initial begin
        int t, e0, d0, c, n, len, hcnt;
        logic [H_ADDR_W-1:0]  h0, hb, hp;
        logic [NI_ADDR_W-1:0] rb, rp;

        repeat (3) tick();
        chk("rst pe_vld", pe_vld_o, 0);
        chk("rst spmm_vld", spmm_vld_o, 0);
        chk("rst done", done_o, 0);
        chk("rst col", col_idx_o, 0);
        chk("rst val", val_o, 0);
        chk("rst row_len", row_len_o, 0);
        chk("rst h_addrb", h_addrb, 0);
        chk("rst ni_addrb", ni_addrb, 0);
        rst = 1'b0;
        tick();

        // Single row of three elements.
        set_row(10, 3, 7, 1'b1);
        set_h(100, 5, 10); set_h(101, 7, -2); set_h(102, 9, 4);
        e0 = elem_q.size();
        run("single", 10, 1, 100, 1'b0);
        if (elem_q.size() - e0 == 3) begin
            chk("single val1", elem_q[e0+1].val, 8'hFE);
            chk("single col2", elem_q[e0+2].col, 9);
        end

        // Two rows back to back with credit held high.
        rdy_force = 1'b1;
        set_row(20, 2, 3, 1'b0); set_row(21, 1, 5, 1'b1);
        set_h(200, 11, 21); set_h(201, 12, 22); set_h(202, 13, 23);
        run("two_rows", 20, 2, 200, 1'b1);
        rdy_force = 1'b0;

        // Credit stall before the second row.
        set_row(30, 2, 9, 1'b0); set_row(31, 1, 4, 1'b1);
        set_h(300, 31, 41); set_h(301, 32, 42); set_h(302, 33, 43);
        e0 = elem_q.size();
        d0 = done_q.size();
        build_exp(30, 2, 300);
        do_start(30, 2, 300, t);
        while (cyc < t + 8) tick();
        h0 = h_addrb;
        repeat (10) begin
            tick();
            chk("stall h_addrb", h_addrb, h0);
        end
        chk("stall no_vld", elem_q.size() - e0, 2);
        c = cyc;
        rdy_force = 1'b1;
        #1;
        chk("credit h_addrb", h_addrb, 302);
        wait_done("stall", d0, 100);
        tick();
        check_result("stall", t, e0, d0, 1'b0);
        if (elem_q.size() - e0 == 3) chk("stall resume_cyc", elem_q[e0+2].cyc, c + 2);

        // Zero-length middle row; a start pulse mid-run must be ignored.
        set_row(40, 2, 1, 1'b0); set_row(41, 0, 2, 1'b1); set_row(42, 2, 3, 1'b0);
        set_h(400, 51, 61); set_h(401, 52, 62); set_h(402, 53, 63); set_h(403, 54, 64);
        e0 = elem_q.size();
        d0 = done_q.size();
        build_exp(40, 3, 400);
        do_start(40, 3, 400, t);
        tick();
        row_base_i = 10; num_rows_i = '0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done("zero_row", d0, 100);
        tick();
        check_result("zero_row", t, e0, d0, 1'b1);
        if (elem_q.size() - e0 == 5) begin
            chk("zero_row col", elem_q[e0+2].col, 0);
            chk("zero_row val", elem_q[e0+2].val, 0);
            chk("zero_row len", elem_q[e0+2].rlen, 1);
        end
        rdy_force = 1'b0;

        // num_rows 0 completes immediately.
        e0 = elem_q.size();
        d0 = done_q.size();
        do_start(5, 0, 0, t);
        wait_done("empty", d0, 10);
        repeat (6) tick();
        if (done_q.size() > d0) chk("empty done_cyc", done_q[d0], t + 1);
        chk("empty done_count", done_q.size() - d0, 1);
        chk("empty no_elems", elem_q.size() - e0, 0);
        chk("empty spmm", spmm_log[t+1], 0);

        // Reset in the middle of a row.
        rdy_force = 1'b1;
        set_row(50, 6, 8, 1'b1);
        for (int j = 0; j < 6; j++) set_h(H_ADDR_W'(500 + j), 70 + j, 80 + j);
        e0 = elem_q.size();
        do_start(50, 1, 500, t);
        n = 0;
        while (elem_q.size() - e0 < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_rst streaming", (elem_q.size() - e0 >= 2), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst pe_vld", pe_vld_o, 0);
        chk("mid_rst spmm_vld", spmm_vld_o, 0);
        chk("mid_rst col", col_idx_o, 0);
        chk("mid_rst val", val_o, 0);
        chk("mid_rst row_len", row_len_o, 0);
        chk("mid_rst num_node", num_node_o, 0);
        chk("mid_rst src", src_flag_o, 0);
        chk("mid_rst done", done_o, 0);
        chk("mid_rst h_addrb", h_addrb, 0);
        tick();
        rst = 1'b0;
        rdy_force = 1'b0;
        e0 = elem_q.size();
        d0 = done_q.size();
        repeat (12) tick();
        chk("mid_rst no_done", done_q.size() - d0, 0);
        chk("mid_rst no_elems", elem_q.size() - e0, 0);

        // Randomized runs with random credit; first run wraps both pointers.
        for (int k = 0; k < 8; k++) begin
            rb = NI_ADDR_W'($urandom);
            hb = H_ADDR_W'($urandom);
            n  = $urandom_range(1, 4);
            if (k == 0) begin
                rb = '1;
                hb = '1 - H_ADDR_W'(1);
            end
            rp = rb;
            hp = hb;
            hcnt = 0;
            for (int r = 0; r < n; r++) begin
                len = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
                set_row(rp, len, $urandom_range(0, 167), 1'($urandom));
                for (int j = 0; j < len; j++)
                    set_h(hp + H_ADDR_W'(j), $urandom_range(0, 1432), $urandom_range(0, 255));
                hp = hp + H_ADDR_W'(len);
                rp = rp + NI_ADDR_W'(1);
                hcnt += len;
            end
            rdy_rand_en = 1'b1;
            run($sformatf("rand%0d", k), rb, n, hb, 1'b0);
            rdy_rand_en = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
